// File: rtl/nord_arith_seq.sv
// nord_arith_seq: 181-style ALU with A/AC/SH registers and a multi-cycle shift/rotate/multiply sequencer.
// Define ARITH_OVF_EN to add the OVF output (signed overflow of the arithmetic-mode result).
module nord_arith_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNTW  = 6
) (
   input  logic             clk,
   input  logic             MCL,
   input  logic [WIDTH-1:0] AA,
   input  logic [WIDTH-1:0] BB,
   input  logic             AKL,
   input  logic             ACKL,
   input  logic [1:0]       SL,
   input  logic             M,
   input  logic [3:0]       S,
   input  logic             C,
   input  logic [2:0]       SEQ_OP,
   input  logic [CNTW-1:0]  SEQ_CNT,
   input  logic             SEQ_GO,
   output logic [WIDTH-1:0] SUM,
   output logic             CO,
   output logic             ZERO,
   output logic [WIDTH-1:0] AC,
   output logic [WIDTH-1:0] SH,
   output logic             BUSY,
   output logic             DONE
`ifdef ARITH_OVF_EN
   ,
   output logic             OVF
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP,
      OP_SHL,
      OP_SHR,
      OP_SHRA,
      OP_ROL,
      OP_MUL,
      OP_LDSH,
      OP_RSV
   } seq_op_t;

   state_t             state, state_next;
   seq_op_t            op_in, op_reg;
   logic [WIDTH-1:0]   a_reg, ac_reg, sh_reg;
   logic [CNTW-1:0]    cnt_reg;

   logic [WIDTH-1:0]   b_op, x_op, logic_res;
   logic               cin;
   logic [WIDTH:0]     arith;

   logic [2*WIDTH-1:0] pair, pair_step;
   logic [WIDTH:0]     mul_t;

   assign op_in = seq_op_t'(SEQ_OP);
   assign AC    = ac_reg;
   assign SH    = sh_reg;
   assign BUSY  = (state == RUN);
   assign DONE  = (state == FIN);

   // ALU: operand select, arithmetic path and logic path
   always_comb begin
      b_op = '0;
      case (SL)
         2'd0:    b_op = BB;
         2'd1:    b_op = sh_reg;
         2'd2:    b_op = ac_reg;
         default: b_op = '0;
      endcase

      x_op = '0;
      case (S[1:0])
         2'd0:    x_op = '1;
         2'd1:    x_op = a_reg;
         2'd2:    x_op = ~a_reg;
         default: x_op = '0;
      endcase

      cin = 1'b0;
      case (S[3:2])
         2'd1:    cin = C;
         2'd3:    cin = 1'b1;
         default: cin = 1'b0;
      endcase

      arith = {1'b0, b_op} + {1'b0, x_op} + {{WIDTH{1'b0}}, cin};

      logic_res = '0;
      case (S)
         4'h0:    logic_res = ~b_op;
         4'h1:    logic_res = ~(a_reg & b_op);
         4'h2:    logic_res = ~b_op | a_reg;
         4'h3:    logic_res = '1;
         4'h4:    logic_res = ~(a_reg | b_op);
         4'h5:    logic_res = ~a_reg;
         4'h6:    logic_res = ~(a_reg ^ b_op);
         4'h7:    logic_res = a_reg | ~b_op;
         4'h8:    logic_res = a_reg & ~b_op;
         4'h9:    logic_res = a_reg ^ b_op;
         4'hA:    logic_res = a_reg;
         4'hB:    logic_res = a_reg | b_op;
         4'hC:    logic_res = '0;
         4'hD:    logic_res = b_op & ~a_reg;
         4'hE:    logic_res = a_reg & b_op;
         default: logic_res = b_op;
      endcase

      SUM  = M ? logic_res : arith[WIDTH-1:0];
      CO   = M ? 1'b0 : arith[WIDTH];
      ZERO = (SUM == '0);
   end

`ifdef ARITH_OVF_EN
   // carry into the MSB recovered from the MSB sum bit and its two operand bits
   assign OVF = M ? 1'b0
                  : ((arith[WIDTH-1] ^ b_op[WIDTH-1] ^ x_op[WIDTH-1]) ^ arith[WIDTH]);
`endif

   // one sequencer step on the {AC,SH} pair
   always_comb begin
      pair      = {ac_reg, sh_reg};
      mul_t     = {1'b0, ac_reg} + (sh_reg[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
      pair_step = pair;
      case (op_reg)
         OP_SHL:  pair_step = {pair[2*WIDTH-2:0], 1'b0};
         OP_SHR:  pair_step = {1'b0, pair[2*WIDTH-1:1]};
         OP_SHRA: pair_step = {pair[2*WIDTH-1], pair[2*WIDTH-1:1]};
         OP_ROL:  pair_step = {pair[2*WIDTH-2:0], pair[2*WIDTH-1]};
         OP_MUL:  pair_step = {mul_t, sh_reg[WIDTH-1:1]};
         default: pair_step = pair;
      endcase
   end

   always_ff @(posedge clk or posedge MCL) begin
      if (MCL) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (SEQ_GO) begin
               case (op_in)
                  OP_SHL, OP_SHR, OP_SHRA, OP_ROL:
                     state_next = (SEQ_CNT != '0) ? RUN : FIN;
                  OP_MUL:  state_next = RUN;
                  default: state_next = FIN;
               endcase
            end
         end
         RUN: begin
            if (cnt_reg == CNTW'(1)) begin
               state_next = FIN;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Register loads happen outside RUN; in IDLE a same-cycle ACKL lands before the first
   // step, except that MUL's accumulator clear takes precedence.
   always_ff @(posedge clk or posedge MCL) begin
      if (MCL) begin
         a_reg   <= '0;
         ac_reg  <= '0;
         sh_reg  <= '0;
         cnt_reg <= '0;
         op_reg  <= OP_NOP;
      end else begin
         if (state != RUN) begin
            if (AKL) begin
               a_reg <= AA;
            end
            if (ACKL) begin
               ac_reg <= SUM;
            end
         end
         if ((state == IDLE) && SEQ_GO) begin
            op_reg <= op_in;
            case (op_in)
               OP_SHL, OP_SHR, OP_SHRA, OP_ROL: cnt_reg <= SEQ_CNT;
               OP_MUL: begin
                  cnt_reg <= CNTW'(WIDTH);
                  ac_reg  <= '0;
               end
               OP_LDSH: sh_reg <= SUM;
               default: ;
            endcase
         end
         if (state == RUN) begin
            ac_reg  <= pair_step[2*WIDTH-1:WIDTH];
            sh_reg  <= pair_step[WIDTH-1:0];
            cnt_reg <= cnt_reg - CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_nord_arith_seq.sv
// Directed bench for nord_arith_seq (WIDTH=16): ALU results, sequencer ops via a scoreboard, reset abort.
module tb_nord_arith_seq;

   logic        clk = 1'b0;
   logic        MCL = 1'b0;
   logic [15:0] AA = '0, BB = '0;
   logic        AKL = 1'b0, ACKL = 1'b0;
   logic [1:0]  SL = '0;
   logic        M = 1'b0;
   logic [3:0]  S = '0;
   logic        C = 1'b0;
   logic [2:0]  SEQ_OP = '0;
   logic [5:0]  SEQ_CNT = '0;
   logic        SEQ_GO = 1'b0;
   logic [15:0] SUM, AC, SH;
   logic        CO, ZERO, BUSY, DONE;
`ifdef ARITH_OVF_EN
   logic        OVF;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [15:0] ac;
      logic [15:0] sh;
      int          busy;
   } exp_t;
   exp_t sb[$];

   nord_arith_seq #(.WIDTH(16), .CNTW(6)) dut (
      .clk(clk), .MCL(MCL), .AA(AA), .BB(BB), .AKL(AKL), .ACKL(ACKL),
      .SL(SL), .M(M), .S(S), .C(C), .SEQ_OP(SEQ_OP), .SEQ_CNT(SEQ_CNT),
      .SEQ_GO(SEQ_GO), .SUM(SUM), .CO(CO), .ZERO(ZERO), .AC(AC), .SH(SH),
      .BUSY(BUSY), .DONE(DONE)
`ifdef ARITH_OVF_EN
      , .OVF(OVF)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_seq(input string tag, input logic [2:0] op, input logic [5:0] cnt,
                          input int exp_busy, input logic [15:0] eac, input logic [15:0] esh,
                          input bit poke);
      exp_t e;
      int   n;
      int   guard;
      e = '{tag, eac, esh, exp_busy};
      sb.push_back(e);
      SEQ_OP  = op;
      SEQ_CNT = cnt;
      SEQ_GO  = 1'b1;
      tick();
      SEQ_GO = 1'b0;
      ACKL   = 1'b0;
      n      = 0;
      guard  = 0;
      while (DONE !== 1'b1 && guard < 200) begin
         if (BUSY === 1'b1) n++;
         if (poke && n == 5) begin
            AKL  = 1'b1;
            ACKL = 1'b1;
            AA   = 16'h1234;
         end else begin
            AKL  = 1'b0;
            ACKL = 1'b0;
         end
         tick();
         guard++;
      end
      AKL  = 1'b0;
      ACKL = 1'b0;
      e = sb.pop_front();
      chk({e.tag, "_done"}, DONE, 1);
      chk({e.tag, "_busy_cycles"}, n, e.busy);
      chk({e.tag, "_ac"}, AC, e.ac);
      chk({e.tag, "_sh"}, SH, e.sh);
      tick();
      chk({e.tag, "_done_drop"}, DONE, 0);
   endtask

   task automatic load_a(input logic [15:0] v);
      AA  = v;
      AKL = 1'b1;
      tick();
      AKL = 1'b0;
   endtask

   task automatic load_ac(input logic [15:0] v);
      M    = 1'b1;
      S    = 4'hF;
      SL   = 2'd0;
      BB   = v;
      ACKL = 1'b1;
      tick();
      ACKL = 1'b0;
   endtask

   task automatic load_sh(input string tag, input logic [15:0] v, input logic [15:0] ac_now);
      M  = 1'b1;
      S  = 4'hF;
      SL = 2'd0;
      BB = v;
      run_seq(tag, 3'd6, 6'd0, 0, ac_now, v, 1'b0);
   endtask

   initial begin
      MCL = 1'b1;
      #2;
      chk("rst_ac", AC, 0);
      chk("rst_sh", SH, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      tick();
      tick();
      MCL = 1'b0;
      tick();

      // ALU arithmetic and logic modes
      load_a(16'h1234);
      SL = 2'd0; BB = 16'h0FFF; M = 1'b0; S = 4'h5; C = 1'b1; #1;
      chk("add_sum", SUM, 16'h2234);
      chk("add_co", CO, 0);
      chk("add_zero", ZERO, 0);
      S = 4'h0; SL = 2'd3; #1;
      chk("ones_sum", SUM, 16'hFFFF);
      chk("ones_co", CO, 0);
      S = 4'h6; SL = 2'd0; C = 1'b1; #1;
      chk("sub_sum", SUM, 16'hFDCB);
      chk("sub_co", CO, 0);
      S = 4'hC; #1;
      chk("bpass_sum", SUM, 16'h0FFF);
      chk("bpass_co", CO, 1);
      M = 1'b1; S = 4'h9; #1;
      chk("xor_sum", SUM, 16'h1DCB);
      chk("logic_co", CO, 0);
      S = 4'hC; #1;
      chk("lzero_zero", ZERO, 1);
      M = 1'b0; S = 4'h1; BB = 16'hEDCC; #1;
      chk("wrap_sum", SUM, 16'h0000);
      chk("wrap_co", CO, 1);
      chk("wrap_zero", ZERO, 1);

      // register loads and B-source selection
      load_ac(16'h8000);
      chk("ackl_ac", AC, 16'h8000);
      SL = 2'd2; #1;
      chk("sl_ac", SUM, 16'h8000);
      load_sh("ldsh1", 16'h0001, 16'h8000);
      M = 1'b1; S = 4'hF; SL = 2'd1; #1;
      chk("sl_sh", SUM, 16'h0001);

      // shifts and rotates
      run_seq("shra4", 3'd3, 6'd4, 4, 16'hF800, 16'h0000, 1'b0);
      load_ac(16'h8000);
      load_sh("ldsh0", 16'h0000, 16'h8000);
      run_seq("rol17", 3'd4, 6'd17, 17, 16'h0001, 16'h0000, 1'b0);
      run_seq("rol0", 3'd4, 6'd0, 0, 16'h0001, 16'h0000, 1'b0);
      run_seq("shl40", 3'd1, 6'd40, 40, 16'h0000, 16'h0000, 1'b0);
      load_ac(16'h8000);
      run_seq("shr3", 3'd2, 6'd3, 3, 16'h1000, 16'h0000, 1'b0);
      run_seq("rsv", 3'd7, 6'd5, 0, 16'h1000, 16'h0000, 1'b0);

      // multiply, with AKL/ACKL poked mid-run
      load_a(16'hFFFF);
      load_sh("ldsh_ff", 16'hFFFF, 16'h1000);
      run_seq("mul_ff", 3'd5, 6'd0, 16, 16'hFFFE, 16'h0001, 1'b1);
      M = 1'b1; S = 4'hA; #1;
      chk("a_kept", SUM, 16'hFFFF);
      load_a(16'h0003);
      load_sh("ldsh_5", 16'h0005, 16'hFFFE);
      run_seq("mul_3x5", 3'd5, 6'd0, 16, 16'h0000, 16'h000F, 1'b0);

      // reset during multiply step 7
      load_a(16'hFFFF);
      load_sh("ldsh_rst", 16'hFFFF, 16'h0000);
      SEQ_OP = 3'd5; SEQ_GO = 1'b1;
      tick();
      SEQ_GO = 1'b0;
      repeat (6) tick();
      chk("mid_busy", BUSY, 1);
      MCL = 1'b1; #1;
      chk("abort_busy", BUSY, 0);
      chk("abort_done", DONE, 0);
      chk("abort_ac", AC, 0);
      chk("abort_sh", SH, 0);
      tick();
      chk("abort_no_done", DONE, 0);
      MCL = 1'b0;
      tick();
      run_seq("post_nop", 3'd0, 6'd0, 0, 16'h0000, 16'h0000, 1'b0);

      // ACKL together with SEQ_GO: shift sees the freshly loaded AC
      M = 1'b1; S = 4'hF; SL = 2'd0; BB = 16'h0003; ACKL = 1'b1;
      run_seq("ackl_go_shl2", 3'd1, 6'd2, 2, 16'h000C, 16'h0000, 1'b0);

      // signed overflow cases
      load_a(16'h7FFF);
      M = 1'b0; S = 4'h1; SL = 2'd0; BB = 16'h0001; #1;
      chk("ovf_sum", SUM, 16'h8000);
      chk("ovf_co", CO, 0);
`ifdef ARITH_OVF_EN
      chk("ovf_set", OVF, 1);
`endif
      load_a(16'hFFFF);
      #1;
      chk("novf_sum", SUM, 16'h0000);
      chk("novf_co", CO, 1);
      chk("novf_zero", ZERO, 1);
`ifdef ARITH_OVF_EN
      chk("novf_clr", OVF, 0);
      load_a(16'h7FFF);
      M = 1'b1; #1;
      chk("ovf_logic", OVF, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nord_arith_seq.md
Name: nord_arith_seq

Overview:
- Parametrised successor to the AMIN arithmetic card.
- Keeps the 181-style ALU with operand registers A, AC and SH, generalised to WIDTH bits.
- Adds a sequencer that runs multi-cycle double-length shifts, rotates and unsigned shift-add multiply on the {AC,SH} pair, with BUSY/DONE handshake to the microsequencer.

Parameters:
WIDTH, 16, data path width in bits (W), W >= 4
CNTW, 6, width of SEQ_CNT; must hold 2W

Ports:
clk  in  1  system clock, all state on rising edge
MCL  in  1  master clear; reset is asynchronous and active-high
AA  in  W  A operand input
BB  in  W  external B operand
AKL  in  1  load A from AA
ACKL  in  1  load AC from SUM
SL  in  2  B select: 0 BB, 1 SH, 2 AC, 3 zero
M  in  1  ALU mode: 0 arithmetic, 1 logic
S  in  4  ALU function select
C  in  1  carry in
SEQ_OP  in  3  sequencer op: 0 nop, 1 SHL, 2 SHR, 3 SHRA, 4 ROL, 5 MUL, 6 LDSH, 7 reserved
SEQ_CNT  in  CNTW  step count for shift/rotate ops
SEQ_GO  in  1  start sequencer op, sampled in IDLE only
SUM  out  W  ALU result (combinational)
CO  out  1  carry out; 0 in logic mode
ZERO  out  1  SUM == 0
AC  out  W  AC register
SH  out  W  SH register
BUSY  out  1  sequencer running
DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (MCL high, async): A, AC and SH = 0; state IDLE; BUSY = 0; DONE = 0. Reset mid-operation aborts the operation with no DONE.
- ALU, M=0: SUM/CO = B + X + cin, computed at W+1 bits.
  - X from S[1:0]: all-ones, A, ~A, 0.
  - cin from S[3:2]: 0, C, 0, 1.
- ALU, M=1 (logic), S=0..15: ~B, ~(A&B), ~B|A, 1, ~(A|B), ~A, ~(A^B), A|~B, A&~B, A^B, A, A|B, 0, B&~A, A&B, B. CO = 0.
- Register loads while not BUSY:
  - AKL: A <= AA.
  - ACKL: AC <= SUM.
  - While BUSY, AKL, ACKL and SEQ_GO are ignored.
  - If ACKL and SEQ_GO occur in the same cycle, ACKL is applied; the sequencer latches the post-load values on its first step.
- States: IDLE, RUN, FIN.
  - IDLE + SEQ_GO, op 1-4 with SEQ_CNT > 0: RUN, counter = SEQ_CNT.
  - IDLE + SEQ_GO, op 5: RUN, counter = W, AC <= 0.
  - IDLE + SEQ_GO, op 6: SH <= SUM, go to FIN.
  - IDLE + SEQ_GO, op 0, op 7, or SEQ_CNT = 0 on op 1-4: FIN with no register change.
  - RUN: one step per clock, counter decrements. On the final step, go to FIN.
  - FIN: DONE = 1 for one cycle, then IDLE.
  - BUSY = 1 exactly in RUN. An N-step op gives BUSY for N cycles, then DONE.
- Shift/rotate steps on the 2W pair P = {AC,SH}:
  - SHL: P <<1, fill 0.
  - SHR: P >>1, fill 0.
  - SHRA: P >>1, fill AC[W-1].
  - ROL: rotate left 1.
  - Counts >= 2W are legal: shifts then yield 0 or sign-fill; rotates wrap modulo 2W.
- MUL step (multiplicand A, multiplier in SH):
  - t = {1'b0,AC} + (SH[0] ? A : 0).
  - {AC,SH} <= {t, SH} >> 1, keeping the low 2W bits.
  - After W steps, {AC,SH} = A*SH_initial, unsigned.
- The combinational ALU stays live during RUN. SUM reflects the current register contents.

Optional Feature:
- Macro ARITH_OVF_EN.
- When defined: adds output port OVF (1 bit), the signed two's-complement overflow of the M=0 operation. OVF = carry into MSB XOR carry out of MSB. OVF = 0 when M=1.
- When undefined: the port and its logic are absent; everything else is identical.

Test Plan (W=16):
- ALU add: A=16'h1234, SL=0, BB=16'h0FFF, M=0, S=4'h5, C=1 -> SUM=16'h2234, CO=0, ZERO=0. Then M=0, S=0, SL=3 -> SUM=16'hFFFF, CO=0.
- MUL: A=16'hFFFF; LDSH with BB=16'hFFFF; then op 5 -> BUSY for 16 cycles, then DONE for 1 cycle, AC=16'hFFFE, SH=16'h0001. AKL pulsed mid-run leaves A unchanged.
- SHRA: AC=16'h8000, SH=16'h0001, cnt=4 -> after 4 BUSY cycles AC=16'hF800, SH=16'h0000.
- ROL: AC=16'h8000, SH=0, cnt=17 -> AC=16'h0001, SH=16'h0000. cnt=0 -> no BUSY, DONE the next cycle, registers unchanged.
- Reset: assert MCL during MUL step 7 -> BUSY, DONE, AC and SH = 0 immediately. After release, a new SEQ_GO is accepted.
- ARITH_OVF_EN: A=16'h7FFF, BB=1, M=0, S=4'h1 -> SUM=16'h8000, OVF=1. A=16'hFFFF, BB=1 -> SUM=0, CO=1, ZERO=1, OVF=0.
